event_timestamper_v2: RTL and testbench

EVENT_TIMESTAMPER_V2 -- requirements
Module: event_timestamper_v2

---
 rtl/event_ts_pkg.sv | 21 ++
 rtl/ev_rec_fifo.sv | 49 ++++
 rtl/event_timestamper_v2.sv | 140 ++++++++++++++
 tb/tb_event_timestamper_v2.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_ts_pkg.sv
// Shared types and helpers for the event timestamper.
package event_ts_pkg;

  localparam int unsigned DefIdW = 3;
  localparam int unsigned DefTsW = 8;

  // Record layout at default widths; the FIFO stores the same field order flattened.
  typedef struct packed {
    logic [DefIdW-1:0] id;
    logic [DefTsW-1:0] start_ts;
    logic [DefTsW-1:0] end_ts;
    logic [DefTsW-1:0] delta;
    logic              timeout;
  } ev_rec_t;

  // Flattened record width: id, three timestamps, timeout flag.
  function automatic int unsigned rec_width(input int unsigned id_w, input int unsigned ts_w);
    return id_w + 3 * ts_w + 1;
  endfunction

endpackage

// File: rtl/ev_rec_fifo.sv
// Synchronous show-ahead record FIFO; head word is visible whenever not empty.
module ev_rec_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Occupancy from pointers carrying one extra wrap bit.
  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    full    = (count == (Aw + 1)'(Depth));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem_q[rd_ptr_q[Aw-1:0]];
  end

  // Pointer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (Aw + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (Aw + 1)'(1);
    end
  end

  // Storage, not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/event_timestamper_v2.sv
// Pairs start/end events per ID, timestamps them and queues completed records.
module event_timestamper_v2
  import event_ts_pkg::*;
#(
  parameter int unsigned ID_W       = 3,
  parameter int unsigned TS_W       = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [ID_W-1:0] start_id,
  input  logic            end_valid,
  output logic            end_ready,
  input  logic [ID_W-1:0] end_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id,
  output logic [TS_W-1:0] out_start_ts,
  output logic [TS_W-1:0] out_end_ts,
  output logic [TS_W-1:0] out_delta,
  output logic            out_timeout,
  output logic            err_dup_start,
  output logic            err_orphan_end,
  output logic [ID_W:0]   active_cnt
);

  localparam int unsigned     NumIds    = 2 ** ID_W;
  localparam int unsigned     RecW      = rec_width(ID_W, TS_W);
  localparam int unsigned     CntW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TS_W-1:0] TimeoutTs = TS_W'(TIMEOUT);
  localparam bit              TimeoutEn = (TIMEOUT != 0);

  logic [TS_W-1:0]   cnt_q;
  logic [NumIds-1:0] active_q, active_d;
  logic [TS_W-1:0]   start_ts_q [NumIds];
  logic [ID_W-1:0]   scan_q, scan_d;
  logic              err_dup_q, err_orphan_q;

  logic              start_fire, end_fire, end_hit, expire, scan_block;
  logic [TS_W-1:0]   end_delta, scan_age;
  logic              push, pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [RecW-1:0]   wdata, rdata;

  // Handshakes; an end on the same ID as a start wins and the start retries.
  always_comb begin
    start_ready = !rst && !(end_valid && (end_id == start_id));
    end_ready   = !rst && (fifo_count < CntW'(FIFO_DEPTH));
    start_fire  = start_valid && start_ready;
    end_fire    = end_valid && end_ready;
    end_hit     = end_fire && active_q[end_id];
    end_delta   = cnt_q - start_ts_q[end_id];
  end

  // Timeout scanner: one ID per cycle, yields to end writes and live handshakes.
  always_comb begin
    scan_age   = cnt_q - start_ts_q[scan_q];
    scan_block = fifo_full || end_hit || (start_fire && (start_id == scan_q)) ||
                 (end_fire && (end_id == scan_q));
    expire     = TimeoutEn && active_q[scan_q] && (scan_age >= TimeoutTs) && !scan_block;
    scan_d     = scan_block ? scan_q : scan_q + ID_W'(1);
  end

  // Record selection; end handshake has priority over a timeout close.
  always_comb begin
    push  = 1'b0;
    wdata = '0;
    if (end_hit) begin
      push  = 1'b1;
      wdata = {end_id, start_ts_q[end_id], cnt_q, end_delta, 1'b0};
    end else if (expire) begin
      push  = 1'b1;
      wdata = {scan_q, start_ts_q[scan_q], cnt_q, scan_age, 1'b1};
    end
  end

  // Open-ID set update; the three sources always target distinct IDs.
  always_comb begin
    active_d = active_q;
    if (end_hit)    active_d[end_id]   = 1'b0;
    if (expire)     active_d[scan_q]   = 1'b0;
    if (start_fire) active_d[start_id] = 1'b1;
  end

  // Population count of open IDs.
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < NumIds; i++) active_cnt = active_cnt + (ID_W + 1)'(active_q[i]);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      active_q     <= '0;
      scan_q       <= '0;
      err_dup_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + TS_W'(1);
      active_q     <= active_d;
      scan_q       <= scan_d;
      err_dup_q    <= start_fire && active_q[start_id];
      err_orphan_q <= end_fire && !active_q[end_id];
    end
  end

  // Start timestamps; stale values are harmless because active_q gates them.
  always_ff @(posedge clk) begin
    if (start_fire) start_ts_q[start_id] <= cnt_q;
  end

  ev_rec_fifo #(
    .Width (RecW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output stream driven straight from the FIFO head.
  always_comb begin
    out_valid      = !rst && !fifo_empty;
    pop            = out_valid && out_ready;
    {out_id, out_start_ts, out_end_ts, out_delta, out_timeout} = rdata;
    err_dup_start  = err_dup_q;
    err_orphan_end = err_orphan_q;
  end

endmodule

// File: tb/tb_event_timestamper_v2.sv
// Directed and random checks of event_timestamper_v2 against a queue-based model.
module tb_event_timestamper_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid, end_valid, out_ready;
  logic [2:0] start_id, end_id;

  logic       start_ready, end_ready, out_valid, out_timeout, err_dup_start, err_orphan_end;
  logic [2:0] out_id;
  logic [7:0] out_start_ts, out_end_ts, out_delta;
  logic [3:0] active_cnt;

  logic       to_start_ready, to_end_ready, to_out_valid, to_out_timeout, to_err_dup, to_err_orph;
  logic [2:0] to_out_id;
  logic [7:0] to_out_start_ts, to_out_end_ts, to_out_delta;
  logic [3:0] to_active_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  event_timestamper_v2 #(.ID_W(3), .TS_W(8), .FIFO_DEPTH(4), .TIMEOUT(0)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
    .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_delta(out_delta),
    .out_timeout(out_timeout), .err_dup_start(err_dup_start),
    .err_orphan_end(err_orphan_end), .active_cnt(active_cnt)
  );

  event_timestamper_v2 #(.ID_W(3), .TS_W(8), .FIFO_DEPTH(4), .TIMEOUT(20)) dut_to (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(to_start_ready), .start_id(start_id),
    .end_valid(end_valid), .end_ready(to_end_ready), .end_id(end_id),
    .out_valid(to_out_valid), .out_ready(out_ready), .out_id(to_out_id),
    .out_start_ts(to_out_start_ts), .out_end_ts(to_out_end_ts), .out_delta(to_out_delta),
    .out_timeout(to_out_timeout), .err_dup_start(to_err_dup),
    .err_orphan_end(to_err_orph), .active_cnt(to_active_cnt)
  );

  // Reference model for the TIMEOUT=0 instance.
  typedef struct {
    int unsigned id;
    int unsigned st;
    int unsigned en;
    int unsigned dl;
    bit          to;
  } rec_t;

  int unsigned cnt_m;
  bit          act_m [8];
  int unsigned ts_m  [8];
  rec_t        q     [$];
  bit          dup_m, orph_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_active();
    int unsigned n = 0;
    for (int i = 0; i < 8; i++) n += act_m[i];
    return n;
  endfunction

  task automatic drive(input bit sv, input int sid, input bit ev, input int eid, input bit ordy);
    start_valid = sv;
    start_id    = 3'(sid);
    end_valid   = ev;
    end_id      = 3'(eid);
    out_ready   = ordy;
  endtask

  // One clock: check readies, advance the model at the edge, check outputs.
  task automatic cycle();
    bit s_rdy, e_rdy, s_fire, e_fire, do_pop;
    int unsigned sid, eid;
    #1;
    s_rdy = !(end_valid && (end_id == start_id));
    e_rdy = q.size() < 4;
    chk("start_ready", 32'(start_ready), 32'(s_rdy));
    chk("end_ready", 32'(end_ready), 32'(e_rdy));
    s_fire = start_valid && s_rdy;
    e_fire = end_valid && e_rdy;
    do_pop = (q.size() > 0) && out_ready;
    sid    = start_id;
    eid    = end_id;
    @(posedge clk);
    dup_m  = s_fire && act_m[sid];
    orph_m = e_fire && !act_m[eid];
    if (do_pop) void'(q.pop_front());
    if (e_fire && act_m[eid]) begin
      q.push_back('{eid, ts_m[eid], cnt_m, (cnt_m + 256 - ts_m[eid]) % 256, 1'b0});
      act_m[eid] = 1'b0;
    end
    if (s_fire) begin
      act_m[sid] = 1'b1;
      ts_m[sid]  = cnt_m;
    end
    cnt_m = (cnt_m + 1) % 256;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_id", 32'(out_id), q[0].id);
      chk("out_start_ts", 32'(out_start_ts), q[0].st);
      chk("out_end_ts", 32'(out_end_ts), q[0].en);
      chk("out_delta", 32'(out_delta), q[0].dl);
      chk("out_timeout", 32'(out_timeout), 32'(q[0].to));
    end
    chk("err_dup_start", 32'(err_dup_start), 32'(dup_m));
    chk("err_orphan_end", 32'(err_orphan_end), 32'(orph_m));
    chk("active_cnt", 32'(active_cnt), model_active());
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, ordy);
      cycle();
    end
  endtask

  task automatic idle_until(input int unsigned target, input bit ordy);
    while (cnt_m != target) idle(1, ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_start_ready", 32'(start_ready), 0);
    chk("rst_end_ready", 32'(end_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_errs", 32'({err_dup_start, err_orphan_end}), 0);
    chk("rst_active_cnt", 32'(active_cnt), 0);
    chk("rst_to_start_ready", 32'(to_start_ready), 0);
    chk("rst_to_out_valid", 32'(to_out_valid), 0);
    chk("rst_to_active_cnt", 32'(to_active_cnt), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);
    cnt_m = 0;
    q.delete();
    for (int i = 0; i < 8; i++) act_m[i] = 1'b0;
    @(negedge clk);
    cnt_m = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int unsigned s1;

    // Basic record with known stamps.
    do_reset();
    idle_until(5, 1);
    drive(1, 3, 0, 0, 1); cycle();
    idle_until(11, 1);
    drive(0, 0, 1, 3, 1); cycle();
    chk("basic_id", 32'(out_id), 3);
    chk("basic_start", 32'(out_start_ts), 5);
    chk("basic_end", 32'(out_end_ts), 11);
    chk("basic_delta", 32'(out_delta), 6);
    chk("basic_timeout", 32'(out_timeout), 0);
    idle(2, 1);

    // Counter wrap.
    idle_until(250, 1);
    drive(1, 2, 0, 0, 1); cycle();
    idle_until(4, 1);
    drive(0, 0, 1, 2, 1); cycle();
    chk("wrap_start", 32'(out_start_ts), 250);
    chk("wrap_end", 32'(out_end_ts), 4);
    chk("wrap_delta", 32'(out_delta), 10);
    idle(2, 1);

    // Ordering and full-FIFO backpressure.
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, i, 0, 0, 0); cycle(); end
    drive(0, 0, 1, 1, 0); cycle();
    drive(0, 0, 1, 0, 0); cycle();
    drive(0, 0, 1, 2, 0); cycle();
    chk("order_head", 32'(out_id), 1);
    drive(0, 0, 1, 3, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 4, 0);
      #1 chk("full_end_ready", 32'(end_ready), 0);
      cycle();
    end
    drive(0, 0, 1, 4, 1); cycle();
    drive(0, 0, 1, 4, 1); cycle();
    idle(6, 1);
    chk("drained", 32'(out_valid), 0);

    // Same-ID start/end collision.
    drive(1, 5, 0, 0, 1); cycle();
    idle(3, 1);
    drive(1, 5, 1, 5, 1);
    #1 chk("collide_start_ready", 32'(start_ready), 0);
    cycle();
    s1 = cnt_m;
    drive(1, 5, 0, 0, 1); cycle();
    idle(2, 1);
    drive(0, 0, 1, 5, 1); cycle();
    chk("collide_restart_ts", 32'(out_start_ts), s1);

    // Orphan end and duplicate start.
    do_reset();
    drive(0, 0, 1, 6, 1); cycle();
    chk("orphan_pulse", 32'(err_orphan_end), 1);
    chk("orphan_no_rec", 32'(out_valid), 0);
    idle(1, 1);
    chk("orphan_one_pulse", 32'(err_orphan_end), 0);
    drive(1, 1, 0, 0, 1); cycle();
    idle(2, 1);
    s1 = cnt_m;
    drive(1, 1, 0, 0, 1); cycle();
    chk("dup_pulse", 32'(err_dup_start), 1);
    idle(2, 1);
    drive(0, 0, 1, 1, 1); cycle();
    chk("dup_second_ts", 32'(out_start_ts), s1);
    idle(2, 1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 9) < 7);
      cycle();
    end
    idle(8, 1);

    // Forced close on the TIMEOUT=20 instance.
    do_reset();
    idle_until(10, 0);
    drive(1, 4, 0, 0, 0); cycle();
    chk("to_active_one", 32'(to_active_cnt), 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle(1, 0);
      if (to_out_valid === 1'b1) seen = 1'b1;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_id", 32'(to_out_id), 4);
    chk("to_flag", 32'(to_out_timeout), 1);
    chk("to_start", 32'(to_out_start_ts), 10);
    chk("to_end_range", 32'(to_out_end_ts >= 8'd30 && to_out_end_ts <= 8'd37), 1);
    chk("to_delta", 32'(to_out_delta), 32'(8'(to_out_end_ts - 8'd10)));
    chk("to_delta_min", 32'(to_out_delta >= 8'd20), 1);
    chk("to_active_zero", 32'(to_active_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
